psum_packer: RTL and testbench
==============================

PSUM_PACKER -- requirements
Module: psum_packer

Interface
REQ-001 SHALL have parameter Size, default 9: number of lanes in the packed output vector.
REQ-002 SHALL have parameter DataWidth, default 8: operand width.
REQ-003 SHALL have parameter PsumWidth, default DataWidth*2: width of one partial sum.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_psum/in_last valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-008 SHALL have port in_psum  input  PsumWidth  one partial sum, unsigned.
REQ-009 SHALL have port in_last  input  1  accepted element closes the current group early.
REQ-010 SHALL have port out_valid  output  1  psum vector complete and held.
REQ-011 SHALL have port out_ready  input  1  downstream accumulator takes the vector.
REQ-012 SHALL have port psum  output  Size*PsumWidth  packed vector; lane i at bits [(i+1)*PsumWidth-1 -: PsumWidth].
REQ-013 SHALL have port out_count  output  $clog2(Size+1)  number of filled lanes in psum, 1..Size.

Function
REQ-014 SHALL accept an input element only on a cycle where in_valid && in_ready.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-016 SHALL operate as a two-state FSM: FILL (out_valid=0) and HOLD (out_valid=1).
REQ-017 SHALL, in FILL, write an accepted element into lane idx and increment idx; the first element of a group goes to lane 0.
REQ-018 SHALL go from FILL to HOLD on the edge that accepts the element at idx==Size-1, or an element with in_last=1, whichever comes first.
REQ-019 SHALL assert out_valid on the cycle after the closing element is accepted (1-cycle latency).
REQ-020 SHALL hold every lane not written in the current group at zero, so short groups are zero-padded.
REQ-021 SHALL set out_count to the number of elements accepted in the group when entering HOLD.
REQ-022 SHALL keep psum, out_count and out_valid stable in HOLD until out_ready=1.
REQ-023 SHALL, on a HOLD cycle with out_ready=1 and no input accept, clear all lanes, set idx=0 and return to FILL.
REQ-024 SHALL, on a HOLD cycle with out_ready=1 and a simultaneous input accept, clear lanes 1..Size-1, write the new element to lane 0 and set idx=1. If that element has in_last=1 or Size==1, it SHALL stay in HOLD with out_count=1.
REQ-025 SHALL ignore in_psum and in_last on cycles without an accept.
REQ-026 SHALL store lane data verbatim, with no arithmetic, truncation or sign extension.
REQ-027 SHALL keep idx within 0..Size-1 at all times.

Reset
REQ-028 SHALL, on any rising edge with rst_n=0, clear all lanes, set idx=0, out_count=0, out_valid=0 and state=FILL.
REQ-029 SHALL discard a partially filled group when reset is asserted mid-operation; after rst_n rises, the next accepted element goes to lane 0.
REQ-030 SHALL not accept input while rst_n=0, although in_ready is combinationally 1 in that case.

Verification (Size=9, PsumWidth=16)
REQ-031 Full group: feed 1..9 back-to-back with out_ready=1. Required: out_valid=1 the cycle after the 9th accept; lane0=1 … lane8=9; out_count=9.
REQ-032 Short group: feed 0x00AA, then 0x00BB with in_last=1. Required: lane0=0x00AA, lane1=0x00BB, lanes 2..8=0, out_count=2.
REQ-033 Backpressure: complete a group with out_ready=0 for 5 cycles. Required: in_ready=0 and psum stable throughout; a single handshake occurs when out_ready rises.
REQ-034 Simultaneous handoff: in HOLD, assert out_ready=1 with in_valid=1 and in_psum=0x1234. Required: the next vector has lane0=0x1234 and lanes 1..8=0, with no element lost or duplicated.
REQ-035 Reset mid-group: accept 4 elements, pulse rst_n=0 for 1 cycle, then feed 9 elements 0x10..0x18. Required: lane0=0x10, out_count=9, no residue from the earlier elements.
REQ-036 Saturation values: feed 0xFFFF in every lane. Required: psum is all ones, out_count=9.

Source files
------------

// File: rtl/psum_packer.sv
// Packs a stream of unsigned partial sums into a Size-lane vector for the downstream
// accumulator. Short groups (closed by in_last) are zero-padded.
module psum_packer #(
    parameter int Size      = 9,
    parameter int DataWidth = 8,
    parameter int PsumWidth = DataWidth * 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PsumWidth-1:0]         in_psum,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [Size*PsumWidth-1:0]    psum,
    output logic [$clog2(Size+1)-1:0]    out_count
);

    localparam int IdxW = (Size > 1) ? $clog2(Size) : 1;
    localparam int CntW = $clog2(Size + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [PsumWidth-1:0]  lanes_q [Size];
    logic [PsumWidth-1:0]  lanes_d [Size];
    logic                  accept;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_count = cnt_q;

    for (genvar g = 0; g < Size; g++) begin : g_pack
        assign psum[(g+1)*PsumWidth-1 -: PsumWidth] = lanes_q[g];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < Size; i++) begin
                        if (idx_q == IdxW'(i)) lanes_d[i] = in_psum;
                    end
                    if (in_last || idx_q == IdxW'(Size - 1)) begin
                        state_d = HOLD;
                        idx_d   = '0;
                        cnt_d   = CntW'(idx_q) + CntW'(1);
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Vector leaves this cycle; an element arriving now opens the next group.
                    for (int i = 0; i < Size; i++) lanes_d[i] = '0;
                    idx_d   = '0;
                    state_d = FILL;
                    if (accept) begin
                        lanes_d[0] = in_psum;
                        if (in_last || Size == 1) begin
                            state_d = HOLD;
                            cnt_d   = CntW'(1);
                        end else begin
                            idx_d = IdxW'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < Size; i++) lanes_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: tb/tb_psum_packer.sv
// Scoreboard bench for psum_packer: a reference packer builds the expected vectors as
// elements are accepted, and a monitor compares each vector at its output handshake.
module tb_psum_packer;

    localparam int Size      = 9;
    localparam int PsumWidth = 16;
    localparam int VecW      = Size * PsumWidth;
    localparam int CntW      = $clog2(Size + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PsumWidth-1:0] in_psum = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [VecW-1:0]      psum;
    logic [CntW-1:0]      out_count;

    psum_packer #(.Size(Size), .DataWidth(8), .PsumWidth(PsumWidth)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .psum      (psum),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VecW-1:0] vec;
        int              cnt;
    } exp_t;

    exp_t                 sb[$];
    exp_t                 mon_e;
    logic [PsumWidth-1:0] m_lanes [Size];
    int                   m_cnt = 0;
    int                   errors = 0;
    int                   checks = 0;
    int                   hs = 0;

    task automatic chk(input string tag, input logic [VecW-1:0] got, input logic [VecW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < Size; i++) m_lanes[i] = '0;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [PsumWidth-1:0] v, input logic last);
        exp_t e;
        m_lanes[m_cnt] = v;
        m_cnt++;
        if (m_cnt == Size || last) begin
            e.vec = '0;
            for (int i = 0; i < Size; i++) e.vec[i*PsumWidth +: PsumWidth] = m_lanes[i];
            e.cnt = m_cnt;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // Holds the element until it is taken; inputs change 1 time unit after the edge.
    task automatic send(input logic [PsumWidth-1:0] v, input logic last);
        int  n = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_psum  = v;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                model_accept(v, last);
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    chk("send_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_psum  = PsumWidth'($urandom);
        in_last  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs++;
            if (sb.size() == 0) begin
                chk("unexpected_vec", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("psum", psum, mon_e.vec);
                chk("out_count", VecW'(out_count), VecW'(mon_e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VecW-1:0] snap;
        int              hs0;
        model_clear();

        // Reset: drive a would-be element that must not be taken
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_psum  = 16'hDEAD;
        idle(2);
        chk("rst_valid", VecW'(out_valid), 0);
        chk("rst_psum", psum, 0);
        chk("rst_count", VecW'(out_count), 0);
        chk("rst_in_ready", VecW'(in_ready), 1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(1);

        // Full group 1..9
        for (int i = 1; i <= Size; i++) begin
            send(PsumWidth'(i), 1'b0);
            chk(i == Size ? "full_latency" : "full_filling", VecW'(out_valid), VecW'(i == Size));
        end
        idle(2);

        // Short group
        send(16'h00AA, 1'b0);
        send(16'h00BB, 1'b1);
        chk("short_latency", VecW'(out_valid), 1);
        idle(2);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= Size; i++) send(PsumWidth'(16'h0100 + i), 1'b0);
        chk("bp_valid_set", VecW'(out_valid), 1);
        snap = psum;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", VecW'(in_ready), 0);
            chk("bp_psum_stable", psum, snap);
            chk("bp_valid_held", VecW'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        hs0 = hs;
        out_ready = 1'b1;
        idle(1);
        chk("bp_one_handshake", VecW'(hs - hs0), 1);
        chk("bp_valid_clear", VecW'(out_valid), 0);
        idle(2);
        chk("bp_still_one", VecW'(hs - hs0), 1);

        // Simultaneous handoff closing at once (in_last)
        out_ready = 1'b0;
        send(16'h0021, 1'b0);
        send(16'h0022, 1'b0);
        send(16'h0023, 1'b1);
        idle(2);
        out_ready = 1'b1;
        send(16'h1234, 1'b1);
        chk("handoff_stays_hold", VecW'(out_valid), 1);
        idle(2);

        // Simultaneous handoff opening a new group
        out_ready = 1'b0;
        for (int i = 0; i < Size; i++) send(PsumWidth'(16'h0040 + i), 1'b0);
        idle(1);
        out_ready = 1'b1;
        send(16'h0055, 1'b0);
        chk("handoff_to_fill", VecW'(out_valid), 0);
        send(16'h0056, 1'b1);
        idle(2);

        // Reset mid-group
        for (int i = 0; i < 4; i++) send(PsumWidth'(16'h0077 + i), 1'b0);
        rst_n = 1'b0;
        model_clear();
        idle(1);
        chk("midrst_valid", VecW'(out_valid), 0);
        rst_n = 1'b1;
        for (int i = 0; i < Size; i++) send(PsumWidth'(16'h0010 + i), 1'b0);
        idle(2);

        // All-ones saturation pattern
        for (int i = 0; i < Size; i++) send(16'hFFFF, 1'b0);
        idle(3);

        chk("sb_empty", VecW'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
